instr_line_width_converter: RTL and testbench

// - Parametrised cache-line to core-word converter between the L1 instruction cache and a core fetch port.
// - Supports up to MAX_OUTSTANDING pipelined cache requests, in-order responses.
// - Holds a last-line buffer, so sequential fetches within a line bypass the cache.
// - flush_i (fence.i) invalidates that buffer.

---
 rtl/instr_line_width_converter_pkg.sv | 24 ++
 rtl/instr_line_width_converter_sel_fifo.sv | 69 ++++++
 rtl/instr_line_width_converter.sv | 142 ++++++++++++++
 tb/tb_instr_line_width_converter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_line_width_converter_pkg.sv
// rtl/instr_line_width_converter_pkg.sv - shared parameters and FIFO entry type for the line-to-word converter
package instr_conv_pkg;

  // Default configuration of the converter.
  localparam int unsigned DEF_ADDR_W          = 32;
  localparam int unsigned DEF_CORE_DW         = 32;
  localparam int unsigned DEF_CACHE_DW        = 128;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;

  // Address split for the default configuration.
  localparam int unsigned LINE_OFF = $clog2(DEF_CACHE_DW / 8);
  localparam int unsigned WORD_OFF = $clog2(DEF_CORE_DW / 8);
  localparam int unsigned WIDX_W   = LINE_OFF - WORD_OFF;
  localparam int unsigned TAG_W    = DEF_ADDR_W - LINE_OFF;

  // One in-flight cache request: which line, which word of it, and the
  // buffer epoch at issue time (a mismatch on return means a flush happened).
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [WIDX_W-1:0] widx;
    logic              epoch;
  } sel_entry_t;

endpackage

// File: rtl/instr_line_width_converter_sel_fifo.sv
// rtl/instr_line_width_converter_sel_fifo.sv - in-order tracking FIFO for outstanding cache requests
module instr_sel_fifo
  import instr_conv_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_MAX_OUTSTANDING,
  parameter type         entry_t = sel_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // A pop frees the slot the simultaneous push writes into, so push is legal when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is read straight from storage; no fall-through of the incoming entry.
  assign rdata = mem[rd_ptr_q];

  // Entry storage, written at the tail.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_line_width_converter.sv
// rtl/instr_line_width_converter.sv - cache-line to core-word fetch converter with last-line buffer
module instr_line_width_converter
  import instr_conv_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned CORE_DW         = DEF_CORE_DW,
  parameter int unsigned CACHE_DW        = DEF_CACHE_DW,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                core_req_i,
  output logic                core_gnt_o,
  input  logic [ADDR_W-1:0]   core_addr_i,
  output logic [CORE_DW-1:0]  core_r_rdata_o,
  output logic                core_r_valid_o,
  output logic                cache_req_o,
  input  logic                cache_gnt_i,
  output logic [ADDR_W-1:0]   cache_addr_o,
  input  logic [CACHE_DW-1:0] cache_r_rdata_i,
  input  logic                cache_r_valid_i
);

  localparam int unsigned LINE_LSB = $clog2(CACHE_DW / 8);
  localparam int unsigned WORD_LSB = $clog2(CORE_DW / 8);
  localparam int unsigned IDX_W    = LINE_LSB - WORD_LSB;
  localparam int unsigned TAG_BITS = ADDR_W - LINE_LSB;
  localparam int unsigned WORDS    = CACHE_DW / CORE_DW;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [IDX_W-1:0]    widx;
    logic                epoch;
  } entry_t;

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_W-1:0]    req_widx;
  logic                unused_sub_word;

  logic                buf_valid_q;
  logic [TAG_BITS-1:0] buf_tag_q;
  logic [CACHE_DW-1:0] buf_line_q;
  logic                epoch_q;
  logic                hit_rsp_q;
  logic [IDX_W-1:0]    hit_widx_q;

  logic                hit;
  logic                push;
  logic                pop;
  logic                fill;
  logic                fifo_full;
  logic                fifo_empty;
  entry_t              push_entry;
  entry_t              head;

  logic [CORE_DW-1:0]  cache_words [WORDS];
  logic [CORE_DW-1:0]  buf_words   [WORDS];

  assign req_tag         = core_addr_i[ADDR_W-1:LINE_LSB];
  assign req_widx        = core_addr_i[LINE_LSB-1:WORD_LSB];
  assign unused_sub_word = ^core_addr_i[WORD_LSB-1:0];

  // The buffer may only answer when nothing is in flight, which keeps
  // responses in order and means a hit never collides with a cache response.
  assign hit = core_req_i & buf_valid_q & (req_tag == buf_tag_q) & fifo_empty & ~flush_i;

  assign cache_req_o  = core_req_i & ~hit & ~fifo_full;
  assign cache_addr_o = {req_tag, {LINE_LSB{1'b0}}};
  assign push         = cache_req_o & cache_gnt_i;
  assign core_gnt_o   = hit | push;

  assign push_entry = '{tag: req_tag, widx: req_widx, epoch: epoch_q};
  assign pop        = cache_r_valid_i & ~fifo_empty;
  // A line issued before the latest flush is stale for the buffer even though the core still gets its word.
  assign fill       = pop & (head.epoch == epoch_q) & ~flush_i;

  instr_sel_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .entry_t (entry_t)
  ) u_sel_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  for (genvar w = 0; w < WORDS; w++) begin : g_words
    assign cache_words[w] = cache_r_rdata_i[w*CORE_DW +: CORE_DW];
    assign buf_words[w]   = buf_line_q[w*CORE_DW +: CORE_DW];
  end

  // Line buffer, flush epoch and the one-cycle delayed local-hit response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_line_q  <= '0;
      epoch_q     <= 1'b0;
      hit_rsp_q   <= 1'b0;
      hit_widx_q  <= '0;
    end else begin
      hit_rsp_q <= hit;
      if (hit) begin
        hit_widx_q <= req_widx;
      end
      if (flush_i) begin
        buf_valid_q <= 1'b0;
        epoch_q     <= ~epoch_q;
      end else if (fill) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= head.tag;
        buf_line_q  <= cache_r_rdata_i;
      end
    end
  end

  // Response mux: a cache line passes straight through, else the buffered word answers a hit.
  always_comb begin
    core_r_valid_o = cache_r_valid_i | hit_rsp_q;
    core_r_rdata_o = '0;
    if (cache_r_valid_i) begin
      core_r_rdata_o = cache_words[head.widx];
    end else if (hit_rsp_q) begin
      core_r_rdata_o = buf_words[hit_widx_q];
    end
  end

  a_rvalid_without_request: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(cache_r_valid_i && fifo_empty));

  a_width_ratio: assert property (
    @(posedge clk_i) (CACHE_DW % CORE_DW) == 0);

  a_rvalid_known: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !$isunknown(core_r_valid_o));

endmodule

// File: tb/tb_instr_line_width_converter.sv
// tb/tb_instr_line_width_converter.sv - self-checking bench for instr_line_width_converter
module tb_instr_line_width_converter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic         core_req_i;
  logic         core_gnt_o;
  logic [31:0]  core_addr_i;
  logic [31:0]  core_r_rdata_o;
  logic         core_r_valid_o;
  logic         cache_req_o;
  logic         cache_gnt_i;
  logic [31:0]  cache_addr_o;
  logic [127:0] cache_r_rdata_i;
  logic         cache_r_valid_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  instr_line_width_converter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .core_req_i     (core_req_i),
    .core_gnt_o     (core_gnt_o),
    .core_addr_i    (core_addr_i),
    .core_r_rdata_o (core_r_rdata_o),
    .core_r_valid_o (core_r_valid_o),
    .cache_req_o    (cache_req_o),
    .cache_gnt_i    (cache_gnt_i),
    .cache_addr_o   (cache_addr_o),
    .cache_r_rdata_i(cache_r_rdata_i),
    .cache_r_valid_i(cache_r_valid_i)
  );

  typedef struct {
    logic         req;
    logic [31:0]  addr;
    logic         fl;
    logic         cg;
    logic         rv;
    logic [127:0] line;
    logic         e_gnt;
    logic         e_creq;
    logic [31:0]  e_caddr;
    logic         e_rv;
    logic [31:0]  e_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } creq_t;

  vec_t        tbl[$];
  creq_t       cq[$];
  logic [31:0] eq[$];

  // Backing memory: every word holds a tag derived from its own word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA500_0000 | {8'h00, a[23:2], 2'b00};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'h0};
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = word_of(base + 32'(k * 4));
    return l;
  endfunction

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic fl,
                              input logic cg, input logic rv, input logic [127:0] line,
                              input logic e_gnt, input logic e_creq, input logic [31:0] e_caddr,
                              input logic e_rv, input logic [31:0] e_rdata);
    vec_t v;
    v.req = req; v.addr = addr; v.fl = fl; v.cg = cg; v.rv = rv; v.line = line;
    v.e_gnt = e_gnt; v.e_creq = e_creq; v.e_caddr = e_caddr; v.e_rv = e_rv; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic fl,
                       input logic cg, input logic rv, input logic [127:0] line);
    @(negedge clk_i);
    core_req_i      = req;
    core_addr_i     = addr;
    flush_i         = fl;
    cache_gnt_i     = cg;
    cache_r_valid_i = rv;
    cache_r_rdata_i = line;
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic e_gnt, input logic e_creq,
                             input logic [31:0] e_caddr, input logic e_rv, input logic [31:0] e_rdata);
    chk({tag, "_gnt"}, core_gnt_o, e_gnt);
    chk({tag, "_creq"}, cache_req_o, e_creq);
    if (e_creq) chk({tag, "_caddr"}, cache_addr_o, e_caddr);
    chk({tag, "_rvalid"}, core_r_valid_o, e_rv);
    if (e_rv) chk({tag, "_rdata"}, core_r_rdata_o, e_rdata);
  endtask

  task automatic idle_inputs();
    core_req_i = 0; core_addr_i = 0; flush_i = 0;
    cache_gnt_i = 0; cache_r_valid_i = 0; cache_r_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 0;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

  initial begin
    logic [127:0] l1;
    int outstanding_before;
    int hits;

    rst_ni = 0;
    idle_inputs();
    repeat (3) @(negedge clk_i);
    #1;
    expect_outs("reset", 0, 0, 32'h0, 0, 32'h0);
    chk("reset_rdata", core_r_rdata_o, 32'h0);
    chk("reset_caddr", cache_addr_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1;

    // Directed per-cycle vectors: single miss, sequential hits, outstanding limit.
    l1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tbl.push_back(mk(1, 32'h1008, 0, 1, 0, '0,            1, 1, 32'h1000, 0, 0));
    tbl.push_back(mk(0, 32'h0,    0, 0, 0, '0,            0, 0, 0,        0, 0));
    tbl.push_back(mk(0, 32'h0,    0, 0, 0, '0,            0, 0, 0,        0, 0));
    tbl.push_back(mk(0, 32'h0,    0, 0, 1, l1,            0, 0, 0,        1, 32'h3333_3333));
    tbl.push_back(mk(1, 32'h1000, 0, 0, 0, '0,            1, 0, 0,        0, 0));
    tbl.push_back(mk(1, 32'h1004, 0, 0, 0, '0,            1, 0, 0,        1, 32'h1111_1111));
    tbl.push_back(mk(1, 32'h1008, 0, 0, 0, '0,            1, 0, 0,        1, 32'h2222_2222));
    tbl.push_back(mk(1, 32'h100C, 0, 0, 0, '0,            1, 0, 0,        1, 32'h3333_3333));
    tbl.push_back(mk(0, 32'h0,    0, 0, 0, '0,            0, 0, 0,        1, 32'h4444_4444));
    tbl.push_back(mk(1, 32'h2000, 0, 1, 0, '0,            1, 1, 32'h2000, 0, 0));
    tbl.push_back(mk(1, 32'h3004, 0, 1, 0, '0,            1, 1, 32'h3000, 0, 0));
    tbl.push_back(mk(1, 32'h2008, 0, 1, 0, '0,            0, 0, 0,        0, 0));
    tbl.push_back(mk(1, 32'h2008, 0, 1, 1, line_of(32'h2000), 0, 0, 0,    1, word_of(32'h2000)));
    tbl.push_back(mk(1, 32'h2008, 0, 1, 1, line_of(32'h3000), 1, 1, 32'h2000, 1, word_of(32'h3004)));
    tbl.push_back(mk(0, 32'h0,    0, 0, 0, '0,            0, 0, 0,        0, 0));
    tbl.push_back(mk(0, 32'h0,    0, 0, 1, line_of(32'h2000), 0, 0, 0,    1, word_of(32'h2008)));
    tbl.push_back(mk(1, 32'h200C, 0, 0, 0, '0,            1, 0, 0,        0, 0));
    tbl.push_back(mk(0, 32'h0,    0, 0, 0, '0,            0, 0, 0,        1, word_of(32'h200C)));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].addr, tbl[i].fl, tbl[i].cg, tbl[i].rv, tbl[i].line);
      expect_outs($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_creq, tbl[i].e_caddr,
                  tbl[i].e_rv, tbl[i].e_rdata);
    end

    // Flush with a miss outstanding: data still returned, no refill.
    drive(1, 32'h5000, 0, 1, 0, '0);               expect_outs("fl_issue", 1, 1, 32'h5000, 0, 0);
    drive(0, 32'h0, 1, 0, 0, '0);                  expect_outs("fl_flush", 0, 0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 1, line_of(32'h5000));   expect_outs("fl_resp", 0, 0, 0, 1, word_of(32'h5000));
    drive(1, 32'h5004, 0, 0, 0, '0);               expect_outs("fl_refetch", 0, 1, 32'h5000, 0, 0);
    drive(1, 32'h2004, 0, 0, 0, '0);               expect_outs("fl_oldbuf", 0, 1, 32'h2000, 0, 0);

    // Flush in the same cycle as the response.
    drive(1, 32'h6000, 0, 1, 0, '0);               expect_outs("flc_issue", 1, 1, 32'h6000, 0, 0);
    drive(0, 32'h0, 1, 0, 1, line_of(32'h6000));   expect_outs("flc_resp", 0, 0, 0, 1, word_of(32'h6000));
    drive(1, 32'h6004, 0, 0, 0, '0);               expect_outs("flc_nohit", 0, 1, 32'h6000, 0, 0);
    drive(1, 32'h6004, 0, 1, 0, '0);               expect_outs("flc_reissue", 1, 1, 32'h6000, 0, 0);
    drive(0, 32'h0, 0, 0, 1, line_of(32'h6000));   expect_outs("flc_fill", 0, 0, 0, 1, word_of(32'h6004));
    drive(1, 32'h6009, 0, 0, 0, '0);               expect_outs("flc_hit", 1, 0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0, '0);                  expect_outs("flc_hitrsp", 0, 0, 0, 1, word_of(32'h6008));

    // Reset mid-burst: FIFO full and buffer valid beforehand.
    drive(1, 32'h7000, 0, 1, 0, '0);               expect_outs("rst_a", 1, 1, 32'h7000, 0, 0);
    drive(1, 32'h8000, 0, 1, 0, '0);               expect_outs("rst_b", 1, 1, 32'h8000, 0, 0);
    drive(1, 32'h6004, 0, 1, 0, '0);               expect_outs("rst_full", 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 0;
    idle_inputs();
    @(posedge clk_i);
    #1;
    expect_outs("rst_mid", 0, 0, 0, 0, 0);
    chk("rst_mid_rdata", core_r_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1;
    drive(1, 32'h6004, 0, 0, 0, '0);               expect_outs("rst_after", 0, 1, 32'h6000, 0, 0);

    // Randomized traffic against a memory model: every granted fetch must
    // come back in order with the word stored at its address.
    do_reset();
    hits = 0;
    for (int cyc = 0; cyc < 4030; cyc++) begin
      @(negedge clk_i);
      outstanding_before = cq.size();
      if (cq.size() > 0 && cq[0].due <= cyc) begin
        cache_r_valid_i = 1;
        cache_r_rdata_i = line_of(cq[0].addr);
        void'(cq.pop_front());
      end else begin
        cache_r_valid_i = 0;
        cache_r_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      core_req_i  = (cyc < 4000) && ($urandom_range(0, 3) != 0);
      core_addr_i = 32'h1000 + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 15));
      flush_i     = (cyc < 4000) && ($urandom_range(0, 24) == 0);
      cache_gnt_i = ($urandom_range(0, 2) != 0);
      #1;
      if (cache_r_valid_i) chk("rnd_rvalid_pass", core_r_valid_o, 1);
      if (core_r_valid_o) begin
        if (eq.size() == 0) chk("rnd_spurious_rvalid", core_r_valid_o, 0);
        else chk("rnd_rdata", core_r_rdata_o, eq.pop_front());
      end
      if (outstanding_before == 2) chk("rnd_full_block", cache_req_o, 0);
      if (cache_req_o) chk("rnd_caddr", cache_addr_o, core_addr_i & 32'hFFFF_FFF0);
      if (core_gnt_o) begin
        chk("rnd_gnt_req", core_req_i, 1);
        eq.push_back(word_of(core_addr_i));
        if (!cache_req_o) hits++;
      end
      if (cache_req_o && cache_gnt_i) begin
        chk("rnd_gnt_path", core_gnt_o, 1);
        cq.push_back('{core_addr_i & 32'hFFFF_FFF0, cyc + int'($urandom_range(1, 4))});
      end
    end
    chk("rnd_drain_core", eq.size(), 0);
    chk("rnd_drain_cache", cq.size(), 0);
    chk("rnd_hits_seen", (hits > 0) ? 32'd1 : 32'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
